// File: rtl/temp_cal_seq.sv
// Sequencer for the temperature-calibration datapath: services EEPROM writes and
// A2D conversions, steps the datapath through load/multiply, and registers the result.
module temp_cal_seq #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic        wr_req,
  input  logic        wr_sel,
  input  logic [11:0] wr_data,
  input  logic        a2d_done,
  input  logic [11:0] res,
  output logic        a2d_strt,
  output logic        addr,
  output logic        mult,
  output logic        WE,
  output logic        wrtTmp,
  output logic [11:0] wdata,
  output logic [11:0] temp,
  output logic        rdy,
  output logic        busy,
  output logic        wr_ack,
  output logic        err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StWr, StConv, StLoad, StMul, StCapt} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cnv_pend_q, cnv_pend_d;
  logic [11:0]     temp_q, temp_d;
  logic            rdy_q, rdy_d;
  logic            err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cnv_pend_q <= 1'b0;
      temp_q     <= 12'h000;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cnv_pend_q <= cnv_pend_d;
      temp_q     <= temp_d;
      rdy_q      <= rdy_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cnv_pend_d = cnv_pend_q | strt_cnv;
    temp_d     = temp_q;
    rdy_d      = rdy_q;
    err_d      = err_q;
    a2d_strt   = 1'b0;
    addr       = 1'b0;
    mult       = 1'b0;
    WE         = 1'b0;
    wrtTmp     = 1'b0;
    wr_ack     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Writes win; a request seen here while writing stays queued in cnv_pend.
        if (wr_req) begin
          state_d = StWr;
        end else if (strt_cnv || cnv_pend_q) begin
          state_d    = StConv;
          cnt_d      = '0;
          cnv_pend_d = 1'b0;
          rdy_d      = 1'b0;
        end
      end
      StWr: begin
        WE      = 1'b1;
        wr_ack  = 1'b1;
        addr    = wr_sel;
        state_d = StIdle;
      end
      StConv: begin
        a2d_strt = (cnt_q == '0);
        cnt_d    = cnt_q + 1'b1;
        if (a2d_done) begin
          state_d = StLoad;
          err_d   = 1'b0;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StLoad: begin
        wrtTmp  = 1'b1;
        state_d = StMul;
      end
      StMul: begin
        addr    = 1'b1;
        mult    = 1'b1;
        state_d = StCapt;
      end
      StCapt: begin
        addr    = 1'b1;
        mult    = 1'b1;
        temp_d  = res;
        rdy_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign wdata = wr_data;
  assign temp  = temp_q;
  assign rdy   = rdy_q;
  assign err   = err_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_temp_cal_seq.sv
// Bench for temp_cal_seq: behavioural datapath/A2D environment, transaction-level
// reference model compared every cycle, plus directed literal checks.
module tb_temp_cal_seq;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strt_cnv = 1'b0;
  logic        wr_req = 1'b0;
  logic        wr_sel = 1'b0;
  logic [11:0] wr_data = 12'h000;
  logic        a2d_done = 1'b0;
  logic [11:0] res;
  logic        a2d_strt, addr, mult, WE, wrtTmp, rdy, busy, wr_ack, err;
  logic [11:0] wdata, temp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  temp_cal_seq #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .strt_cnv (strt_cnv),
    .wr_req   (wr_req),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .a2d_done (a2d_done),
    .res      (res),
    .a2d_strt (a2d_strt),
    .addr     (addr),
    .mult     (mult),
    .WE       (WE),
    .wrtTmp   (wrtTmp),
    .wdata    (wdata),
    .temp     (temp),
    .rdy      (rdy),
    .busy     (busy),
    .wr_ack   (wr_ack),
    .err      (err)
  );

  function automatic logic [11:0] sat_add(logic [11:0] a, logic [11:0] off);
    int s = int'(a) + int'($signed(off));
    if (s < 0) s = 0;
    if (s > 4095) s = 4095;
    return 12'(s);
  endfunction

  function automatic logic [11:0] sat_mul(logic [11:0] t, logic [11:0] g);
    longint p = (longint'(t) * longint'(g)) >> 11;
    if (p > 4095) p = 4095;
    return 12'(p);
  endfunction

  // Datapath environment: EEPROM (not cleared by reset), temp register, multiplier.
  logic [11:0] ee [2];
  logic [11:0] dp_tmp = 12'h000;
  logic [11:0] a2d = 12'h000;
  initial begin
    ee[0] = 12'h000;
    ee[1] = 12'h800;
  end
  always @(posedge clk) begin
    if (WE) ee[addr] <= wdata;
    if (wrtTmp) dp_tmp <= sat_add(a2d, ee[addr]);
  end
  assign res = mult ? sat_mul(dp_tmp, ee[addr]) : dp_tmp;

  // Reference model: tracks phase counters, not states.
  logic [11:0] sh [2];
  initial begin
    sh[0] = 12'h000;
    sh[1] = 12'h800;
  end
  bit          m_wr = 0, m_pend = 0, m_rdy = 0, m_err = 0, m_take = 0, m_sel = 0;
  int          m_age = -1, m_post = 0;
  logic [11:0] m_temp = 12'h000, m_next = 12'h000, m_data = 12'h000;
  wire         m_idle = !m_wr && (m_age < 0) && (m_post == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr = 0; m_age = -1; m_post = 0; m_pend = 0; m_rdy = 0; m_err = 0; m_temp = 12'h000;
    end else begin
      m_take = 0;
      if (m_idle) begin
        if (wr_req) begin
          m_wr = 1; m_sel = wr_sel; m_data = wr_data;
        end else if (strt_cnv || m_pend) begin
          m_age = 0; m_rdy = 0; m_take = 1;
        end
      end else if (m_wr) begin
        sh[m_sel] = m_data;
        m_wr = 0;
      end else if (m_age >= 0) begin
        if (a2d_done) begin
          m_age = -1; m_post = 1; m_err = 0;
          m_next = sat_mul(sat_add(a2d, sh[0]), sh[1]);
        end else if (m_age == TO - 1) begin
          m_age = -1; m_err = 1;
        end else begin
          m_age++;
        end
      end else if (m_post == 3) begin
        m_post = 0; m_temp = m_next; m_rdy = 1;
      end else begin
        m_post++;
      end
      if (m_take) m_pend = 0;
      else if (strt_cnv) m_pend = 1;
    end
  end

  logic [32:0] act_v, exp_v;
  always @(negedge clk) begin
    #1;
    act_v = {a2d_strt, addr, mult, WE, wrtTmp, wdata, temp, rdy, busy, wr_ack, err};
    exp_v = {(m_age == 0), (m_wr ? wr_sel : (m_post >= 2)), (m_post >= 2), m_wr, (m_post == 1),
             wr_data, m_temp, m_rdy, !m_idle, m_wr, m_err};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL cycle outputs @%0t: got %h expected %h", $time, act_v, exp_v);
    end
  end

  // A2D stub: new sample on a2d_strt, done after a chosen delay (0 = same cycle).
  bit          use_fixed = 1, no_resp = 0, spurious = 0;
  logic [11:0] fixed_val = 12'h000;
  int          fixed_delay = 2;
  int          cd = -1;
  always @(negedge clk) begin
    a2d_done = 1'b0;
    if (a2d_strt) begin
      a2d = use_fixed ? fixed_val : 12'($urandom);
      cd  = no_resp ? -1 : (use_fixed ? fixed_delay : int'($urandom_range(0, 20)));
    end
    if (cd == 0) begin
      a2d_done = 1'b1;
      cd = -1;
    end else if (cd > 0) begin
      cd--;
    end else if (spurious && m_age < 0 && $urandom_range(0, 15) == 0) begin
      a2d_done = 1'b1;
    end
  end

  int ack_cnt = 0, strt_cnt = 0;
  always @(negedge clk) begin
    if (wr_ack) ack_cnt++;
    if (a2d_strt) strt_cnt++;
  end

  task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic do_write(input logic s, input logic [11:0] d);
    bit ok = 0;
    wr_req = 1'b1; wr_sel = s; wr_data = d;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (wr_ack) begin
        ok = 1;
        break;
      end
    end
    wr_req = 1'b0;
    check("write ack seen", 33'(ok), 33'd1);
    tick();
  endtask

  task automatic wait_result(output logic [11:0] t, output int lat);
    int  seen = -1;
    bit  ok = 0;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (a2d_done && busy && seen < 0) seen = i;
      if (rdy && seen >= 0) begin
        ok = 1;
        lat = i - seen;
        break;
      end
      tick();
    end
    t = temp;
    check("result arrives", 33'(ok), 33'd1);
  endtask

  task automatic do_conv(input logic [11:0] v, input int dly, output logic [11:0] t,
                         output int lat);
    fixed_val = v; fixed_delay = dly;
    strt_cnv = 1'b1;
    tick();
    strt_cnv = 1'b0;
    wait_result(t, lat);
    tick();
  endtask

  logic [11:0] t, t0;
  int          lat, a0, s0, cnt;

  initial begin
    repeat (3) tick();
    check("reset temp", 33'(temp), 33'h000);
    check("reset flags", 33'({rdy, err, busy, a2d_strt, wr_ack, WE, wrtTmp, mult, addr}), 33'h0);
    rst_n = 1'b1;
    tick();

    // Unity gain; rdy seen 4 negedges after done = update at the third edge after done.
    a0 = ack_cnt;
    do_write(1'b1, 12'h800);
    do_write(1'b0, 12'h000);
    check("one wr_ack per write", 33'(ack_cnt - a0), 33'd2);
    do_conv(12'h89A, 3, t, lat);
    check("unity temp", 33'(t), 33'h89A);
    check("unity latency", 33'(lat), 33'd4);

    // Gain 1.5, done in first CONV cycle, then saturation.
    do_write(1'b1, 12'hC00);
    do_conv(12'h89A, 0, t, lat);
    check("gain1.5 temp", 33'(t), 33'hCE7);
    check("same-cycle done latency", 33'(lat), 33'd4);
    do_conv(12'hABC, 5, t, lat);
    check("gain1.5 saturate", 33'(t), 33'hFFF);

    // Negative offset.
    do_write(1'b0, 12'hFFE);
    do_write(1'b1, 12'h800);
    do_conv(12'h003, 1, t, lat);
    check("neg offset 3-2", 33'(t), 33'h001);
    do_conv(12'h001, 2, t, lat);
    check("neg offset clamp", 33'(t), 33'h000);

    // Write and conversion requested together: write first.
    fixed_val = 12'h100; fixed_delay = 2;
    wr_req = 1'b1; wr_sel = 1'b0; wr_data = 12'h000; strt_cnv = 1'b1;
    tick();
    strt_cnv = 1'b0;
    check("write before conv", 33'({wr_ack, a2d_strt, busy}), 33'b101);
    wr_req = 1'b0;
    wait_result(t, lat);
    check("queued conv temp", 33'(t), 33'h100);
    tick();

    // Requests during a conversion collapse into one extra conversion.
    fixed_delay = 3;
    strt_cnv = 1'b1;
    tick();
    strt_cnv = 1'b1;
    tick();
    strt_cnv = 1'b0;
    for (int i = 0; i < 40 && !mult; i++) tick();
    strt_cnv = 1'b1;
    s0 = strt_cnt;
    tick();
    strt_cnv = 1'b0;
    repeat (40) tick();
    check("one queued a2d_strt", 33'(strt_cnt - s0), 33'd1);

    // Timeout after exactly TO CONV cycles, temp kept.
    no_resp = 1;
    t0 = temp;
    strt_cnv = 1'b1;
    tick();
    strt_cnv = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      cnt++;
      tick();
    end
    check("timeout cycles", 33'(cnt), 33'(TO));
    check("timeout err", 33'(err), 33'd1);
    check("timeout temp kept", 33'(temp), 33'(t0));
    check("timeout rdy low", 33'(rdy), 33'd0);
    no_resp = 0;
    tick();
    do_conv(12'h234, 4, t, lat);
    check("good conv temp", 33'(t), 33'h234);
    check("good conv clears err", 33'(err), 33'd0);

    // Reset while in LOAD with a conversion pending.
    fixed_delay = 2;
    strt_cnv = 1'b1;
    tick();
    tick();
    strt_cnv = 1'b0;
    for (int i = 0; i < 40 && !wrtTmp; i++) tick();
    rst_n = 1'b0;
    #1;
    check("reset mid-LOAD outputs",
          33'({a2d_strt, addr, mult, WE, wrtTmp, temp, rdy, busy, wr_ack, err}), 33'h0);
    tick();
    rst_n = 1'b1;
    s0 = strt_cnt;
    repeat (10) tick();
    check("pending dropped by reset", 33'(strt_cnt - s0), 33'd0);
    do_conv(12'h3C5, 1, t, lat);
    check("conv after reset", 33'(t), 33'h3C5);

    // Randomized traffic; the per-cycle compare does the checking.
    use_fixed = 0; spurious = 1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_n = ($urandom_range(0, 999) != 0);
      strt_cnv = strt_cnv ? 1'b0 : ($urandom_range(0, 24) == 0);
      if (wr_req && wr_ack) begin
        wr_req = 1'b0;
      end else if (!wr_req && $urandom_range(0, 59) == 0) begin
        wr_req  = 1'b1;
        wr_sel  = 1'($urandom_range(0, 1));
        wr_data = wr_sel ? 12'($urandom_range(12'h600, 12'hC00)) : 12'($urandom);
      end
    end
    rst_n = 1'b1; strt_cnv = 1'b0; wr_req = 1'b0; spurious = 0;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/temp_cal_seq.md
# temp_cal_seq

Sequencer that drives the temperature-calibration datapath (offset-add / gain-multiply with saturation, EEPROM offset at addr 0, gain at addr 1, 0x800 = unity gain). It accepts host conversion requests and EEPROM write requests. It handshakes with the A2D front end, steps the datapath through its load-temp and multiply phases, and registers the calibrated 12-bit result with a ready flag. It sits directly upstream of the datapath and owns its addr, mult, WE, wrtTmp and wdata inputs.

## Interface
Parameters:
- TIMEOUT, 1024: maximum cycles spent waiting for a2d_done before aborting.

Ports:
- clk  in  1  system clock. One clock only; all state updates on its rising edge.
- rst_n  in  1  reset. Asynchronous, active-low.
- strt_cnv  in  1  one-cycle conversion request pulse from host.
- wr_req  in  1  EEPROM write request, level; held by host until wr_ack.
- wr_sel  in  1  write target: 0 = offset, 1 = gain. Stable while wr_req is high.
- wr_data  in  12  EEPROM write value. Stable while wr_req is high.
- a2d_done  in  1  A2D conversion-complete pulse. The A2D holds datapath a2d stable from this pulse until the next a2d_strt.
- res  in  12  datapath result.
- a2d_strt  out  1  one-cycle pulse requesting an A2D conversion.
- addr  out  1  datapath EEPROM select.
- mult  out  1  datapath multiply select.
- WE  out  1  datapath EEPROM write enable.
- wrtTmp  out  1  datapath temp-register write enable.
- wdata  out  12  datapath EEPROM write data.
- temp  out  12  registered calibrated temperature.
- rdy  out  1  temp holds a fresh result.
- busy  out  1  state is not IDLE.
- wr_ack  out  1  one-cycle pulse when the EEPROM write is issued.
- err  out  1  sticky A2D-timeout flag.

## Operation
- States: IDLE, WR, CONV, LOAD, MUL, CAPT.
- cnv_pend flag:
  - Set by strt_cnv in any state.
  - Cleared on the IDLE→CONV transition.
  - A strt_cnv arriving during a conversion queues exactly one further conversion; multiple pulses collapse into one.
- IDLE:
  - If wr_req → WR. Writes take priority.
  - Else if strt_cnv or cnv_pend → CONV.
  - All datapath controls are 0.
- WR (1 cycle):
  - WE=1, addr=wr_sel, wdata=wr_data, wr_ack=1.
  - Next state is IDLE.
- CONV:
  - a2d_strt=1 in the first CONV cycle only.
  - rdy is cleared on entry.
  - A cycle counter starts at 0 and increments each CONV cycle.
  - a2d_done sampled high → LOAD, err cleared.
  - If the counter reaches TIMEOUT-1 without a2d_done → IDLE with err=1.
- LOAD (1 cycle):
  - wrtTmp=1, addr=0, mult=0.
  - The temp register captures sat(a2d+offset) at the end of this cycle.
- MUL (1 cycle): addr=1, mult=1, giving the datapath one full cycle to settle.
- CAPT (1 cycle):
  - addr=1, mult=1.
  - temp←res and rdy←1 at the end of the cycle.
  - Next state is IDLE.
- wdata is driven from wr_data in all states. WE is only ever high in WR.
- This block does no arithmetic; all saturation happens in the datapath.

## Timing
- Reset values:
  - State IDLE.
  - temp=0x000.
  - rdy, err, busy, a2d_strt, wr_ack, WE, wrtTmp, mult, addr, cnv_pend and the counter all 0.
- Reset mid-operation:
  - Returns to IDLE immediately.
  - Any pending conversion is discarded.
  - temp, rdy and err are cleared.
- Conversion latency:
  - strt_cnv sampled in IDLE at edge E0 → a2d_strt high in the cycle after E0.
  - a2d_done sampled at edge En → LOAD, MUL, CAPT occupy the next 3 cycles.
  - temp and rdy update at edge En+3.
- Write latency: wr_req sampled in IDLE at E0 → WE and wr_ack high in the cycle after E0. Earliest next action is at E1.
- a2d_done in CONV's first cycle (same cycle as a2d_strt) is accepted.
- a2d_done outside CONV is ignored.
- A timeout aborts after exactly TIMEOUT CONV cycles. temp keeps its old value, rdy stays 0.
- wr_req asserted during a conversion waits until the return to IDLE. It is then serviced before any queued conversion.

## Test plan
- Unity gain: write gain 0x800, offset 0x000; convert with a2d=0x89A → temp=0x89A, rdy=1 exactly 3 cycles after a2d_done, wr_ack pulsed once per write.
- Gain 1.5: write gain 0xC00, convert a2d=0x89A → temp=0xCE7. Convert a2d=0xABC → temp=0xFFF (saturated).
- Negative offset: offset 0xFFE, gain 0x800. a2d=0x003 → temp=0x001. a2d=0x001 → temp=0x000.
- Priority and queueing:
  - wr_req and strt_cnv in the same IDLE cycle → WR first, then CONV.
  - A strt_cnv during MUL → exactly one extra a2d_strt after CAPT.
- Timeout: TIMEOUT=16, never assert a2d_done → IDLE after 16 CONV cycles, err=1, temp unchanged. The next good conversion clears err.
- Reset mid-LOAD: drop rst_n → all outputs 0 at once, no WE or wrtTmp glitch after release, and the next conversion works normally.
